pipelined_processor: RTL and testbench
======================================

Name: pipelined_processor

Overview:
- 32-bit, five-stage (F/D/E/M/W) in-order pipelined core executing a subset of the ARMv4 (ARM-state) instruction set.
- Sits between an asynchronous-read instruction memory and an asynchronous-read data memory, both external.
- Provides full operand forwarding, load-use stall, branch flush and conditional execution with NZCV flags.

Parameters:
- none (data width fixed at 32; register file fixed at 16 x 32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- inst  input  32  instruction word for address pcf; combinational, same cycle.
- data  input  32  data memory read word for m_address; combinational, same cycle.
- memw_m  output  1  data memory write enable (M stage).
- pcf  output  32  fetch PC to instruction memory.
- m_address  output  32  data memory byte address (M-stage ALU result).
- m_data  output  32  data memory write data (M-stage, forwarded Rd value).

Behaviour:
- Reset (rst=1 at a rising edge):
  - pcf=0.
  - All pipeline registers cleared to bubbles (all control bits 0).
  - Flags NZCV=0; R0-R14 = 0.
  - Outputs after reset: memw_m=0, m_address=0, m_data=0.
  - Reset mid-operation discards all in-flight instructions.
- Fetch: pcf advances by 4 each cycle unless stalled. pcf+4 is pipelined so that any R15 read in D returns fetch-address+8.
- Supported instructions:
  - Data processing, register (no shift) or rotated imm8:
    - AND 0000, SUB 0010, ADD 0100, ORR 1100: write Rd; update flags if S=1.
    - CMP 1010: flags only, no register write.
    - C/V are defined only for ADD/SUB/CMP; logical ops set only N and Z.
  - LDR/STR, immediate offset, U=1/0 add/subtract, pre-indexed, no writeback (op 01, I=0, P=1, W=0).
  - B (op 10, bit24=0): target = PC+8 + (sign-extended imm24 << 2).
- Condition field is evaluated in E against current flags; all 15 ARM codes; 1110=always.
  - A failed condition suppresses register write, memory write, flag write and branch.
- Writes with Rd=15 from data processing or LDR are ignored (no register write).
- Unsupported encodings execute as NOPs.
- Register file: two combinational read ports plus a third for the STR source (Rd). Write occurs in W. A same-cycle write/read of the same register returns the new value (write-through).
- Forwarding: E-stage operands take priority M-stage ALU result, then W-stage result, then register-file value. Match on register number, with the M or W write enable active. Applies to Rn, Rm and STR data.
- Load-use hazard: LDR in E whose Rd matches Rn/Rm/Rd-source of the instruction in D:
  - Stall F and D for one cycle (pcf holds).
  - Insert a bubble into E.
- Branch taken (resolved in E):
  - Next cycle pcf = target.
  - Flush D and E; the two younger instructions never write.
  - Branch penalty is 2 cycles.
- Flag write occurs in E and is visible to the next instruction's condition check.
- Simultaneous stall and branch flush: the flush wins; E is bubbled and pcf loads the target.
- Latency: an instruction fetched at edge n has memw_m/m_address/m_data valid during cycle n+3 and writes its register at the end of cycle n+4.

Decomposition:
- Shared package processor_pkg holds:
  - opcode constants (AND, SUB, ADD, ORR, CMP);
  - op-field constants (DP, MEM, BR);
  - condition-code enum;
  - ALU-control enum;
  - forwarding-select enum;
  - pipeline-register structs per stage.
- One sub-module: hazard_unit, which computes forward selects, stall_f/stall_d and flush_d/flush_e.

Test Plan:
- Reset then SUB R0,PC,PC (E04F000F), ADD R2,R0,#5 (E2802005), STR R2,[R0,#8] (E5802008), each one cycle apart.
  - Required: m_address=8, m_data=5, memw_m=1 exactly one cycle, 3 cycles after the STR fetch.
  - Exercises forwarding from M and W.
- LDR R1,[R0,#4] (E5901004) with data=0x1234, then ADD R3,R1,#1 (E2813001), then STR R3,[R0,#0] (E5803000).
  - Required: pcf repeats one value (one-cycle stall).
  - STR yields m_address=0, m_data=0x1235.
- B at pcf=0x10 (EA000001).
  - Required: pcf sequence 0x10,0x14,0x18,0x1C.
  - Stores placed at 0x14/0x18 produce no memw_m pulse.
- SUB R7,R3,#9 (E2437009) with R3=5, then STR R7,[R0,#0].
  - Required: m_data=0xFFFFFFFC.
- CMP R0,#0 (E3500000) then STRNE R2,[R0] (15802000) and STREQ R2,[R0,#4] (05802004).
  - Required: only the EQ store asserts memw_m, with m_address=4.
- rst asserted for one cycle mid-sequence.
  - Required: next cycle pcf=0, memw_m=0, m_address=0, m_data=0.
  - No stale write occurs after reset.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types and encodings for the five-stage ARMv4-subset core.
package processor_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_CMP = 4'b1010;

  localparam logic [1:0] OPF_DP  = 2'b00;
  localparam logic [1:0] OPF_MEM = 2'b01;
  localparam logic [1:0] OPF_BR  = 2'b10;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_ctrl_e;

  typedef enum logic [1:0] {FWD_RF, FWD_W, FWD_M} fwd_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } fd_t;

  typedef struct packed {
    logic        reg_w;
    logic        mem_w;
    logic        mem_to_reg;
    logic        branch;
    logic        flag_nz;
    logic        flag_cv;
    logic        use_imm;
    alu_ctrl_e   alu;
    cond_e       cond;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] imm;
  } de_t;

  typedef struct packed {
    logic        reg_w;
    logic        mem_w;
    logic        mem_to_reg;
    logic [3:0]  rd;
    logic [31:0] alu;
    logic [31:0] wdata;
  } em_t;

  typedef struct packed {
    logic        reg_w;
    logic        mem_to_reg;
    logic [3:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } mw_t;

  // nzcv packed as {N,Z,C,V}; NV (1111) never passes.
  function automatic logic cond_pass(input cond_e cc, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cc)
      CC_EQ: return z;
      CC_NE: return !z;
      CC_CS: return c;
      CC_CC: return !c;
      CC_MI: return n;
      CC_PL: return !n;
      CC_VS: return v;
      CC_VC: return !v;
      CC_HI: return c && !z;
      CC_LS: return !c || z;
      CC_GE: return n == v;
      CC_LT: return n != v;
      CC_GT: return !z && (n == v);
      CC_LE: return z || (n != v);
      CC_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Forward selection for E-stage operands plus load-use stall and branch flush control.
module hazard_unit
  import processor_pkg::*;
(
  input  logic [3:0] rn_d,
  input  logic [3:0] rm_d,
  input  logic [3:0] rd_d,
  input  logic       use_rn_d,
  input  logic       use_rm_d,
  input  logic       use_rd_d,
  input  logic [3:0] rn_e,
  input  logic [3:0] rm_e,
  input  logic [3:0] rd_e,
  input  logic       ldr_e,
  input  logic       reg_w_m,
  input  logic [3:0] rd_m,
  input  logic       reg_w_w,
  input  logic [3:0] rd_w,
  input  logic       br_taken_e,
  output fwd_e       fwd_a_e,
  output fwd_e       fwd_b_e,
  output fwd_e       fwd_c_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e
);

  function automatic fwd_e pick(input logic [3:0] r);
    if (reg_w_m && rd_m == r) return FWD_M;
    if (reg_w_w && rd_w == r) return FWD_W;
    return FWD_RF;
  endfunction

  logic ld_use;

  assign fwd_a_e = pick(rn_e);
  assign fwd_b_e = pick(rm_e);
  assign fwd_c_e = pick(rd_e);

  // ldr_e is only set for loads with a real destination, so rd_e is the load target.
  assign ld_use = ldr_e && ((use_rn_d && rn_d == rd_e) ||
                            (use_rm_d && rm_d == rd_e) ||
                            (use_rd_d && rd_d == rd_e));

  assign stall_f = ld_use;
  assign stall_d = ld_use;
  assign flush_d = br_taken_e;
  assign flush_e = br_taken_e || ld_use;

endmodule

// File: rtl/pipelined_processor.sv
// Five-stage in-order ARMv4-subset core: DP (AND/SUB/ADD/ORR/CMP), LDR/STR imm, B.
module pipelined_processor
  import processor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] data,
  output logic        memw_m,
  output logic [31:0] pcf,
  output logic [31:0] m_address,
  output logic [31:0] m_data
);

  logic [31:0] pcf_q, pcf_d;
  fd_t         fd_q, fd_d;
  de_t         de_q, de_d;
  em_t         em_q, em_d;
  mw_t         mw_q, mw_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] rf_q [16];
  logic [31:0] rf_d [16];

  de_t         dec;
  logic        use_rn, use_rm, use_rd;
  logic [31:0] pc8_d, res_w;
  logic [4:0]  rot2;
  logic [63:0] rot_tmp;

  fwd_e        fwd_a, fwd_b, fwd_c;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [31:0] src_a, src_b, src_b_reg, str_data, alu_res;
  logic [32:0] sum;
  logic        alu_c, alu_v, pass, br_taken;

  assign res_w = mw_q.mem_to_reg ? mw_q.rdata : mw_q.alu;
  assign pc8_d = fd_q.pc + 32'd8;

  // R15 reads the pipelined PC; everything else is write-through from W.
  function automatic logic [31:0] rf_read(input logic [3:0] r);
    if (r == 4'd15) return pc8_d;
    if (mw_q.reg_w && mw_q.rd == r) return res_w;
    return rf_q[r];
  endfunction

  function automatic logic [31:0] fwd_val(input fwd_e sel, input logic [31:0] rf_val);
    case (sel)
      FWD_M:   return em_q.alu;
      FWD_W:   return res_w;
      default: return rf_val;
    endcase
  endfunction

  // ---------------- Decode ----------------
  always_comb begin
    dec     = '0;
    use_rn  = 1'b0;
    use_rm  = 1'b0;
    use_rd  = 1'b0;
    rot2    = {fd_q.inst[11:8], 1'b0};
    rot_tmp = {24'd0, fd_q.inst[7:0], 24'd0, fd_q.inst[7:0]} >> rot2;
    dec.cond = cond_e'(fd_q.inst[31:28]);
    dec.rn   = fd_q.inst[19:16];
    dec.rm   = fd_q.inst[3:0];
    dec.rd   = fd_q.inst[15:12];
    if (fd_q.vld) begin
      case (fd_q.inst[27:26])
        OPF_DP: begin
          if (fd_q.inst[25] || fd_q.inst[11:4] == 8'd0) begin
            dec.use_imm = fd_q.inst[25];
            dec.imm     = rot_tmp[31:0];
            case (fd_q.inst[24:21])
              OP_AND: begin dec.alu = ALU_AND; dec.reg_w = 1'b1; dec.flag_nz = fd_q.inst[20]; end
              OP_ORR: begin dec.alu = ALU_ORR; dec.reg_w = 1'b1; dec.flag_nz = fd_q.inst[20]; end
              OP_ADD: begin
                dec.alu = ALU_ADD; dec.reg_w = 1'b1;
                dec.flag_nz = fd_q.inst[20]; dec.flag_cv = fd_q.inst[20];
              end
              OP_SUB: begin
                dec.alu = ALU_SUB; dec.reg_w = 1'b1;
                dec.flag_nz = fd_q.inst[20]; dec.flag_cv = fd_q.inst[20];
              end
              OP_CMP: begin
                dec.alu = ALU_SUB;
                dec.flag_nz = fd_q.inst[20]; dec.flag_cv = fd_q.inst[20];
              end
              default: ;
            endcase
            use_rn    = dec.reg_w || dec.flag_nz;
            use_rm    = use_rn && !fd_q.inst[25];
            dec.reg_w = dec.reg_w && (dec.rd != 4'd15);
          end
        end
        OPF_MEM: begin
          // Pre-indexed, immediate, word, no writeback only.
          if (fd_q.inst[25:24] == 2'b01 && fd_q.inst[22:21] == 2'b00) begin
            dec.alu     = fd_q.inst[23] ? ALU_ADD : ALU_SUB;
            dec.use_imm = 1'b1;
            dec.imm     = {20'd0, fd_q.inst[11:0]};
            use_rn      = 1'b1;
            if (fd_q.inst[20]) begin
              dec.mem_to_reg = 1'b1;
              dec.reg_w      = dec.rd != 4'd15;
            end else begin
              dec.mem_w = 1'b1;
              use_rd    = 1'b1;
            end
          end
        end
        OPF_BR: begin
          if (fd_q.inst[25:24] == 2'b10) begin
            dec.branch  = 1'b1;
            dec.alu     = ALU_ADD;
            dec.use_imm = 1'b1;
            dec.rn      = 4'd15;
            dec.imm     = {{6{fd_q.inst[23]}}, fd_q.inst[23:0], 2'b00};
          end
        end
        default: ;
      endcase
    end
    dec.a = rf_read(dec.rn);
    dec.b = rf_read(dec.rm);
    dec.c = rf_read(dec.rd);
  end

  hazard_unit u_hazard (
    .rn_d      (dec.rn),
    .rm_d      (dec.rm),
    .rd_d      (dec.rd),
    .use_rn_d  (use_rn),
    .use_rm_d  (use_rm),
    .use_rd_d  (use_rd),
    .rn_e      (de_q.rn),
    .rm_e      (de_q.rm),
    .rd_e      (de_q.rd),
    .ldr_e     (de_q.mem_to_reg && de_q.reg_w),
    .reg_w_m   (em_q.reg_w),
    .rd_m      (em_q.rd),
    .reg_w_w   (mw_q.reg_w),
    .rd_w      (mw_q.rd),
    .br_taken_e(br_taken),
    .fwd_a_e   (fwd_a),
    .fwd_b_e   (fwd_b),
    .fwd_c_e   (fwd_c),
    .stall_f   (stall_f),
    .stall_d   (stall_d),
    .flush_d   (flush_d),
    .flush_e   (flush_e)
  );

  // ---------------- Execute ----------------
  always_comb begin
    src_a     = fwd_val(fwd_a, de_q.a);
    src_b_reg = fwd_val(fwd_b, de_q.b);
    str_data  = fwd_val(fwd_c, de_q.c);
    src_b     = de_q.use_imm ? de_q.imm : src_b_reg;
    if (de_q.alu == ALU_SUB) sum = {1'b0, src_a} + {1'b0, ~src_b} + 33'd1;
    else                     sum = {1'b0, src_a} + {1'b0, src_b};
    case (de_q.alu)
      ALU_AND: alu_res = src_a & src_b;
      ALU_ORR: alu_res = src_a | src_b;
      default: alu_res = sum[31:0];
    endcase
    alu_c = sum[32];
    if (de_q.alu == ALU_SUB) alu_v = (src_a[31] != src_b[31]) && (alu_res[31] != src_a[31]);
    else                     alu_v = (src_a[31] == src_b[31]) && (alu_res[31] != src_a[31]);
    pass     = cond_pass(de_q.cond, flags_q);
    br_taken = pass && de_q.branch;
    flags_d  = flags_q;
    if (pass && de_q.flag_nz) flags_d[3:2] = {alu_res[31], alu_res == 32'd0};
    if (pass && de_q.flag_cv) flags_d[1:0] = {alu_c, alu_v};
  end

  // ---------------- Next-state ----------------
  always_comb begin
    if (br_taken)     pcf_d = alu_res;
    else if (stall_f) pcf_d = pcf_q;
    else              pcf_d = pcf_q + 32'd4;

    if (flush_d)      fd_d = '0;
    else if (stall_d) fd_d = fd_q;
    else              fd_d = '{vld: 1'b1, pc: pcf_q, inst: inst};

    de_d = flush_e ? '0 : dec;

    em_d = '{reg_w: de_q.reg_w && pass, mem_w: de_q.mem_w && pass,
             mem_to_reg: de_q.mem_to_reg, rd: de_q.rd, alu: alu_res, wdata: str_data};

    mw_d = '{reg_w: em_q.reg_w, mem_to_reg: em_q.mem_to_reg, rd: em_q.rd,
             alu: em_q.alu, rdata: data};

    rf_d = rf_q;
    if (mw_q.reg_w) rf_d[mw_q.rd] = res_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q   <= '0;
      fd_q    <= '0;
      de_q    <= '0;
      em_q    <= '0;
      mw_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pcf_q   <= pcf_d;
      fd_q    <= fd_d;
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
      flags_q <= flags_d;
      rf_q    <= rf_d;
    end
  end

  assign pcf       = pcf_q;
  assign memw_m    = em_q.mem_w;
  assign m_address = em_q.alu;
  assign m_data    = em_q.wdata;

endmodule

// File: tb/tb_pipelined_processor.sv
// Directed program vectors for pipelined_processor, checking store traffic and fetch PC.
module tb_pipelined_processor;

  localparam logic [31:0] NOP = 32'hE1A0_0000;  // MOV: unsupported, executes as NOP

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst, data, pcf, m_address, m_data;
  logic        memw_m;
  logic [31:0] imem [64];

  always #5 clk = ~clk;

  assign inst = imem[pcf[7:2]];
  assign data = (m_address == 32'h4) ? 32'h0000_1234 : 32'hDEAD_BEEF;

  pipelined_processor dut (
    .clk      (clk),
    .rst      (rst),
    .inst     (inst),
    .data     (data),
    .memw_m   (memw_m),
    .pcf      (pcf),
    .m_address(m_address),
    .m_data   (m_data)
  );

  typedef struct {
    string       name;
    logic [31:0] prog [8];
    int          cnt;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] dat;
  } vec_t;

  int          tests = 0, fails = 0;
  int          st_cnt, st_cyc;
  logic [31:0] st_addr, st_data;
  logic [31:0] pc_tr [32];
  vec_t        vecs [9];

  function automatic vec_t mk(input string n,
                              input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7,
                              input int cnt, input int cyc, input logic [31:0] a, d);
    vec_t v;
    v.name = n;
    v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2; v.prog[3] = w3;
    v.prog[4] = w4; v.prog[5] = w5; v.prog[6] = w6; v.prog[7] = w7;
    v.cnt = cnt; v.cyc = cyc; v.addr = a; v.dat = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_imem();
    for (int k = 0; k < 64; k++) imem[k] = NOP;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Samples ncyc consecutive cycles at negedge; cycle 0 is the first cycle out of reset.
  task automatic run(input int ncyc);
    st_cnt = 0; st_cyc = -1; st_addr = 'x; st_data = 'x;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      pc_tr[c] = pcf;
      if (memw_m === 1'b1) begin
        if (st_cnt == 0) begin
          st_cyc = c; st_addr = m_address; st_data = m_data;
        end
        st_cnt++;
      end
    end
  endtask

  initial begin
    vecs[0] = mk("fwd_mw", 32'hE04F000F, 32'hE2802005, 32'hE5802008, NOP, NOP, NOP, NOP, NOP,
                 1, 5, 32'h8, 32'h5);
    vecs[1] = mk("load_use", 32'hE5901004, 32'hE2813001, 32'hE5803000, NOP, NOP, NOP, NOP, NOP,
                 1, 6, 32'h0, 32'h1235);
    vecs[2] = mk("branch", 32'hE2802007, NOP, NOP, NOP, 32'hEA000001, 32'hE5802000,
                 32'hE5802004, 32'hE5802010, 1, 10, 32'h10, 32'h7);
    vecs[3] = mk("sub_neg", 32'hE2803005, 32'hE2437009, 32'hE5807000, NOP, NOP, NOP, NOP, NOP,
                 1, 5, 32'h0, 32'hFFFF_FFFC);
    vecs[4] = mk("cond_eq", 32'hE2802005, 32'hE3500000, 32'h15802000, 32'h05802004, NOP, NOP,
                 NOP, NOP, 1, 6, 32'h4, 32'h5);
    vecs[5] = mk("flags_mi_cs", 32'hE2504001, 32'h4580400C, 32'h25804020, NOP, NOP, NOP, NOP,
                 NOP, 1, 4, 32'hC, 32'hFFFF_FFFF);
    vecs[6] = mk("rot_imm", 32'hE38054FF, 32'hE5805000, NOP, NOP, NOP, NOP, NOP, NOP,
                 1, 4, 32'h0, 32'hFF00_0000);
    vecs[7] = mk("str_sub_off", 32'hE2806040, 32'hE5066008, NOP, NOP, NOP, NOP, NOP, NOP,
                 1, 4, 32'h38, 32'h40);
    vecs[8] = mk("unsupported", 32'hE3A02009, 32'hE5802000, NOP, NOP, NOP, NOP, NOP, NOP,
                 1, 4, 32'h0, 32'h0);

    clear_imem();
    reset_dut();
    @(negedge clk);
    check("rst_pcf", pcf, 32'h0);
    check("rst_memw", {31'd0, memw_m}, 32'h0);
    check("rst_addr", m_address, 32'h0);
    check("rst_data", m_data, 32'h0);

    for (int i = 0; i < 9; i++) begin
      clear_imem();
      for (int k = 0; k < 8; k++) imem[k] = vecs[i].prog[k];
      reset_dut();
      run(20);
      check({vecs[i].name, "_cnt"}, st_cnt, vecs[i].cnt);
      check({vecs[i].name, "_cyc"}, st_cyc, vecs[i].cyc);
      check({vecs[i].name, "_addr"}, st_addr, vecs[i].addr);
      check({vecs[i].name, "_data"}, st_data, vecs[i].dat);
      if (i == 1) begin
        check("lu_pc2", pc_tr[2], 32'h8);
        check("lu_pc3_hold", pc_tr[3], 32'h8);
        check("lu_pc4", pc_tr[4], 32'hC);
      end
      if (i == 2) begin
        check("br_pc4", pc_tr[4], 32'h10);
        check("br_pc5", pc_tr[5], 32'h14);
        check("br_pc6", pc_tr[6], 32'h18);
        check("br_pc7", pc_tr[7], 32'h1C);
        check("br_pc8", pc_tr[8], 32'h20);
      end
    end

    // Reset while the STR of the forwarding program sits in E.
    clear_imem();
    for (int k = 0; k < 8; k++) imem[k] = vecs[0].prog[k];
    reset_dut();
    run(5);
    check("mid_pre_memw", st_cnt, 0);
    clear_imem();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_pcf", pcf, 32'h0);
    check("mid_memw", {31'd0, memw_m}, 32'h0);
    check("mid_addr", m_address, 32'h0);
    check("mid_data", m_data, 32'h0);
    run(12);
    check("mid_no_stale", st_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
